// File: rtl/mux4to1_rr_if.sv
// Bundle of the four input channels and the single output stream of mux4to1_rr.
// The slave modport is the mux side and the master modport is the environment side.
interface mux4to1_rr_if #(parameter int W = 8);
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux4to1_rr.sv
// 4:1 valid/ready merge into one registered output stream, with round-robin arbitration.
// Defining MUX4_FIXED_PRIO_EN switches to fixed priority, where channel 0 wins, then 1, 2, 3.
module mux4to1_rr #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst,
  mux4to1_rr_if.slave bus
);

  logic [3:0][W-1:0] chan;
  logic [W-1:0]      out_data_q;
  logic [1:0]        out_sel_q;
  logic              out_valid_q;
  logic [1:0]        ptr;
  logic [1:0]        grant;
  logic              grant_vld;
  logic              load_en;

  for (genvar i = 0; i < 4; i++) begin : g_chan
    assign chan[i] = bus.in_data[i*W +: W];
  end

  assign load_en = !out_valid_q || bus.out_ready;

  // In fixed-priority builds ptr stays at 0, so this scan always starts at channel 0.
  always_comb begin
    logic [1:0] idx;
    grant_vld = 1'b0;
    grant     = 2'd0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!grant_vld && bus.in_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  // rst is combined in here so that in_ready drops as soon as rst rises.
  assign bus.in_ready = (grant_vld && load_en && !rst) ? (4'b0001 << grant) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      ptr         <= 2'd0;
    end else if (load_en) begin
      if (grant_vld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= chan[grant];
        out_sel_q   <= grant;
`ifdef MUX4_FIXED_PRIO_EN
        ptr         <= 2'd0;
`else
        ptr         <= grant + 2'd1;
`endif
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4to1_rr.sv
// Directed self-checking bench for mux4to1_rr.
// Inputs change 1 time unit after the rising edge, and checks run in the middle of the cycle.
module tb_mux4to1_rr;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mux4to1_rr_if #(.W(W)) bus ();

  mux4to1_rr #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    bus.in_data = {d3, d2, d1, d0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    set_data(8'h01, 8'h02, 8'h03, 8'h04);
    step();
    step();
    #2;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d expected 0", bus.out_sel); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", bus.out_data); end
    n_cmp++; if (bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", bus.in_ready); end
    // Load one beat, then assert reset between clock edges.
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL reset_preload: got %b expected 1", bus.out_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_async_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_async_ready: got %b expected 0000", bus.in_ready); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_async_data: got %h expected 00", bus.out_data); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_hold: got v=%b rdy=%b expected v=0 rdy=0000", bus.out_valid, bus.in_ready); end
    rst = 1'b0;
    bus.in_valid = 4'b0000;
    step();
  endtask

  task automatic test_single();
    do_reset();
    set_data(8'h00, 8'h00, 8'hA5, 8'h00);
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b1;
    #2;
    n_cmp++; if (bus.in_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b expected 0100", bus.in_ready); end
    step();
    bus.in_valid = 4'b0000;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h expected a5", bus.out_data); end
    n_cmp++; if (bus.out_sel !== 2'd2) begin n_err++; $display("FAIL single_sel: got %0d expected 2", bus.out_sel); end
    // With ptr at 3 and every channel valid, channel 3 wins the next scan.
    bus.in_valid = 4'hF;
    #1;
    n_cmp++; if (bus.in_ready !== 4'b1000) begin n_err++; $display("FAIL single_ptr: got in_ready %b expected 1000", bus.in_ready); end
    bus.in_valid = 4'b0000;
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_empty: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d;
    do_reset();
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_d = 8'h10 + 8'(i % 4);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      n_cmp++; if (bus.out_sel !== 2'(i % 4)) begin n_err++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", i, bus.out_sel, i % 4); end
      n_cmp++; if (bus.out_data !== exp_d) begin n_err++; $display("FAIL rr_data[%0d]: got %h expected %h", i, bus.out_data, exp_d); end
    end
    bus.in_valid = 4'b0000;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++; if (bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 8'h10) begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b sel=%0d d=%h expected v=1 sel=0 d=10", i, bus.out_valid, bus.out_sel, bus.out_data); end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready: got %b expected 0010", bus.in_ready); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd1 || bus.out_data !== 8'h11) begin n_err++; $display("FAIL bp_next: got v=%b sel=%0d d=%h expected v=1 sel=1 d=11", bus.out_valid, bus.out_sel, bus.out_data); end
    bus.in_valid = 4'b0000;
    step();
  endtask

  task automatic test_wrap_skip();
    logic [1:0] exp_sel [3];
    logic [3:0] exp_rdy [3];
    exp_sel = '{2'd0, 2'd1, 2'd0};
    exp_rdy = '{4'b0001, 4'b0010, 4'b0001};
    do_reset();
    set_data(8'h20, 8'h21, 8'h22, 8'h23);
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.in_ready !== exp_rdy[i]) begin n_err++; $display("FAIL wrap_ready[%0d]: got %b expected %b", i, bus.in_ready, exp_rdy[i]); end
      step();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_sel !== exp_sel[i] || bus.out_data !== {6'h08, exp_sel[i]}) begin n_err++; $display("FAIL wrap_beat[%0d]: got v=%b sel=%0d d=%h expected sel=%0d", i, bus.out_valid, bus.out_sel, bus.out_data, exp_sel[i]); end
    end
    bus.in_valid = 4'b0000;
    step();
  endtask

  task automatic test_fixed_prio();
    logic [1:0] exp_sel [4];
`ifdef MUX4_FIXED_PRIO_EN
    exp_sel = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_sel = '{2'd0, 2'd3, 2'd0, 2'd3};
`endif
    do_reset();
    set_data(8'h30, 8'h31, 8'h32, 8'h33);
    bus.in_valid  = 4'b1001;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_sel !== exp_sel[i]) begin n_err++; $display("FAIL prio_sel[%0d]: got v=%b sel=%0d expected v=1 sel=%0d", i, bus.out_valid, bus.out_sel, exp_sel[i]); end
      n_cmp++; if (bus.out_data !== {6'h0C, exp_sel[i]}) begin n_err++; $display("FAIL prio_data[%0d]: got %h expected %h", i, bus.out_data, {6'h0C, exp_sel[i]}); end
    end
    bus.in_valid = 4'b0000;
    step();
  endtask

  initial begin
    bus.in_valid  = 4'b0000;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_fixed_prio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
